aes_key_scheduler: RTL



---
 rtl/aes_key_scheduler_if.sv | 30 +++
 rtl/aes_key_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/aes_key_scheduler_if.sv
// Key-in / round-key-out handshake bundle for aes_key_scheduler.
// master is the scheduler side, slave is the cipher/consumer side.
interface aes_key_scheduler_if #(
  parameter int KEY_BITS = 128
);
  logic [KEY_BITS-1:0] key_in;
  logic                key_valid;
  logic                key_ready;
  logic [127:0]        rk_out;
  logic [3:0]          rk_idx;
  logic                rk_valid;
  logic                rk_ready;
  logic                rk_last;
  logic                busy;
  logic [3:0]          rd_idx;
  logic [127:0]        rd_key;
  logic                store_valid;

  modport master (
    input  key_in, key_valid, rk_ready, rd_idx,
    output key_ready, rk_out, rk_idx, rk_valid,
    output rk_last, busy, rd_key, store_valid
  );

  modport slave (
    output key_in, key_valid, rk_ready, rd_idx,
    input  key_ready, rk_out, rk_idx, rk_valid,
    input  rk_last, busy, rd_key, store_valid
  );
endinterface

// File: rtl/aes_key_scheduler.sv
// Word-serial AES-128/192/256 key schedule streaming 128-bit round keys.
// Optional round-key store enabled by defining KEY_SCHED_STORE_EN.
module sub_byte (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] z
  );
    logic [7:0] r, p;
    r = '0;
    p = x;
    for (int k = 0; k < 8; k++) begin
      if (z[k]) r = r ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // a^254 is the field inverse, and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv;
  endfunction

  logic [7:0] b;
  assign b = ginv(a);
  assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
           ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module aes_key_scheduler #(
  parameter int KEY_BITS = 128
) (
  input logic             clk,
  input logic             rst_n,
  aes_key_scheduler_if.master bus
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK6   = 6'(NK);
  localparam logic [5:0] LASTW = 6'(NW - 1);
  localparam logic [3:0] NR4   = 4'(NR);
  localparam logic [2:0] NKM1  = 3'(NK - 1);

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  state_t       state;
  logic [31:0]  kw  [8];
  logic [31:0]  win [NK];
  logic [31:0]  col [4];
  logic [5:0]   wi;
  logic [2:0]   wm;
  logic [7:0]   rcon;
  logic [31:0]  w1, wk, sub_in, sub_out;
  logic [31:0]  t, w_new;
  logic [127:0] rk_data;
  logic         hs, out_free, advance;
  logic         rk_load, accept;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  assign w1     = win[0];
  assign wk     = win[NK-1];
  assign sub_in = (wm == 3'd0) ? {w1[23:0], w1[31:24]} : w1;

  for (genvar g = 0; g < 4; g++) begin : g_sb
    sub_byte u_sb (
      .a(sub_in[8*g +: 8]),
      .y(sub_out[8*g +: 8])
    );
  end

  always_comb begin
    t = w1;
    unique case (1'b1)
      (wm == 3'd0):            t = sub_out ^ {rcon, 24'h0};
      (NK == 8 && wm == 3'd4): t = sub_out;
      default:                 t = w1;
    endcase
    w_new = (wi < NK6) ? kw[wi[2:0]] : (wk ^ t);
  end

  // the fourth word of a round may only land if the output slot frees up
  assign rk_data  = {col[0], col[1], col[2], w_new};
  assign hs       = bus.rk_valid && bus.rk_ready;
  assign out_free = !bus.rk_valid || bus.rk_ready;
  assign advance  = (state == GEN)
                 && (wi[1:0] != 2'd3 || out_free);
  assign rk_load  = advance && (wi[1:0] == 2'd3);
  assign accept   = (state == IDLE) && bus.key_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.key_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.rk_out    <= '0;
      bus.rk_idx    <= '0;
      bus.rk_valid  <= 1'b0;
      bus.rk_last   <= 1'b0;
      wi            <= '0;
      wm            <= '0;
      rcon          <= 8'h01;
      for (int j = 0; j < 8; j++) kw[j] <= '0;
      for (int j = 0; j < NK; j++) win[j] <= '0;
      for (int j = 0; j < 4; j++) col[j] <= '0;
    end else begin
      if (hs) begin
        bus.rk_valid <= 1'b0;
        bus.rk_last  <= 1'b0;
      end
      if (rk_load) begin
        bus.rk_out   <= rk_data;
        bus.rk_idx   <= wi[5:2];
        bus.rk_valid <= 1'b1;
        bus.rk_last  <= (wi[5:2] == NR4);
      end
      unique case (state)
        IDLE: if (accept) begin
          for (int j = 0; j < NK; j++)
            kw[j] <= bus.key_in[KEY_BITS-1-32*j -: 32];
          wi            <= '0;
          wm            <= '0;
          rcon          <= 8'h01;
          bus.key_ready <= 1'b0;
          bus.busy      <= 1'b1;
          state         <= GEN;
        end
        GEN: if (advance) begin
          win[0] <= w_new;
          for (int j = 1; j < NK; j++) win[j] <= win[j-1];
          col[wi[1:0]] <= w_new;
          wi <= wi + 6'd1;
          wm <= (wm == NKM1) ? 3'd0 : wm + 3'd1;
          if (wi >= NK6 && wm == 3'd0) rcon <= xtime(rcon);
          if (wi == LASTW) state <= DRAIN;
        end
        DRAIN: if (hs && bus.rk_last) begin
          bus.key_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_SCHED_STORE_EN
  logic [127:0] store [15];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < 15; j++) store[j] <= '0;
      bus.store_valid <= 1'b0;
      bus.rd_key      <= '0;
    end else begin
      if (rk_load) store[wi[5:2]] <= rk_data;
      if (rk_load && wi[5:2] == NR4)
        bus.store_valid <= 1'b1;
      else if (accept)
        bus.store_valid <= 1'b0;
      bus.rd_key <= (bus.rd_idx <= NR4)
                  ? store[bus.rd_idx] : '0;
    end
  end
`else
  logic unused_rd_idx;
  assign unused_rd_idx   = ^bus.rd_idx;
  assign bus.rd_key      = '0;
  assign bus.store_valid = 1'b0;
`endif
endmodule
